// File: rtl/uart_defines.sv
// Shared UART definitions: framer state encoding, LCR field positions and
// the error-flag layout of a receive FIFO entry.
package uart_defines;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_PUSH      = 3'd5,
        ST_WAIT_HIGH = 3'd6
    } rx_state_e;

    // Line control register fields
    localparam int LCR_BITS_LO = 0;
    localparam int LCR_BITS_HI = 1;
    localparam int LCR_PE      = 3;
    localparam int LCR_EPS     = 4;
    localparam int LCR_SP      = 5;

    // Error flag positions inside a FIFO entry
    localparam int RF_BREAK = 2;
    localparam int RF_PE    = 1;
    localparam int RF_FE    = 0;

    // Parity bit the transmitter should have sent for this character
    function automatic logic expected_parity(input logic [7:0] ch,
                                             input logic eps,
                                             input logic sp);
        if (sp)
            return ~eps;
        else if (eps)
            return ^ch;
        else
            return ~(^ch);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous level input; idles high so a
// reset line does not look like a start bit.
module uart_sync2 (
    input  logic clk,
    input  logic wb_rst_i,
    input  logic d,
    output logic q
);

    logic meta_reg;

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            meta_reg <= 1'b1;
            q        <= 1'b1;
        end else begin
            meta_reg <= d;
            q        <= meta_reg;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: oversamples the line at 16x baud, assembles 5-8 bit
// characters and writes one {char, break, parity_err, framing_err} entry per frame.
module uart_rx_frame
    import uart_defines::*;
#(
    parameter int fifo_width = 11,
    parameter int sample_w   = 4
) (
    input  logic                  clk,
    input  logic                  wb_rst_i,
    input  logic                  enable,
    input  logic                  srx_pad_i,
    input  logic [7:0]            lcr,
    input  logic                  rx_reset,
    output logic                  rf_push,
    output logic [fifo_width-1:0] rf_data_in,
    output logic                  rx_busy
);

    localparam logic [sample_w-1:0] CNT_HALF = sample_w'(7);
    localparam logic [sample_w-1:0] CNT_FULL = sample_w'(15);

    logic                srx;
    rx_state_e           state_reg;
    logic [sample_w-1:0] cnt_reg;
    logic [2:0]          bit_idx_reg;
    logic [7:0]          char_reg;
    logic                par_bit_reg;
    logic                par_err_reg;
    logic                fe_reg;

    logic [2:0]            last_idx;
    logic                  brk;
    logic [fifo_width-1:0] entry;
    logic                  lcr_unused;

    uart_sync2 u_sync (
        .clk      (clk),
        .wb_rst_i (wb_rst_i),
        .d        (srx_pad_i),
        .q        (srx)
    );

    assign lcr_unused = ^{lcr[7:6], lcr[2]};
    assign last_idx   = {1'b0, lcr[LCR_BITS_HI:LCR_BITS_LO]} + 3'd4;

    // A break is an all-zero frame: zero data, zero parity (if any), zero stop.
    assign brk = fe_reg & (char_reg == 8'h00) & (~lcr[LCR_PE] | ~par_bit_reg);

    always_comb begin
        entry = '0;
        if (brk) begin
            entry[RF_BREAK] = 1'b1;
        end else begin
            entry[fifo_width-1 -: 8] = char_reg;
            entry[RF_PE]             = par_err_reg & lcr[LCR_PE];
            entry[RF_FE]             = fe_reg;
        end
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            char_reg    <= '0;
            par_bit_reg <= 1'b0;
            par_err_reg <= 1'b0;
            fe_reg      <= 1'b0;
            rf_push     <= 1'b0;
            rf_data_in  <= '0;
            rx_busy     <= 1'b0;
        end else if (rx_reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            rf_push     <= 1'b0;
            rx_busy     <= 1'b0;
        end else begin
            rf_push <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (enable && !srx) begin
                        state_reg <= ST_START;
                        cnt_reg   <= CNT_HALF;
                        rx_busy   <= 1'b1;
                    end
                end
                ST_START: begin
                    if (enable) begin
                        if (cnt_reg == '0) begin
                            if (srx) begin
                                state_reg <= ST_IDLE;
                                rx_busy   <= 1'b0;
                            end else begin
                                state_reg   <= ST_DATA;
                                cnt_reg     <= CNT_FULL;
                                bit_idx_reg <= '0;
                                char_reg    <= '0;
                                par_bit_reg <= 1'b0;
                                par_err_reg <= 1'b0;
                                fe_reg      <= 1'b0;
                            end
                        end else begin
                            cnt_reg <= cnt_reg - 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (enable) begin
                        if (cnt_reg == '0) begin
                            char_reg[bit_idx_reg] <= srx;
                            cnt_reg               <= CNT_FULL;
                            bit_idx_reg           <= bit_idx_reg + 3'd1;
                            if (bit_idx_reg == last_idx)
                                state_reg <= lcr[LCR_PE] ? ST_PARITY : ST_STOP;
                        end else begin
                            cnt_reg <= cnt_reg - 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (enable) begin
                        if (cnt_reg == '0) begin
                            par_bit_reg <= srx;
                            par_err_reg <= srx != expected_parity(char_reg, lcr[LCR_EPS], lcr[LCR_SP]);
                            cnt_reg     <= CNT_FULL;
                            state_reg   <= ST_STOP;
                        end else begin
                            cnt_reg <= cnt_reg - 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (enable) begin
                        if (cnt_reg == '0) begin
                            fe_reg    <= ~srx;
                            state_reg <= ST_PUSH;
                        end else begin
                            cnt_reg <= cnt_reg - 1'b1;
                        end
                    end
                end
                ST_PUSH: begin
                    rf_push    <= 1'b1;
                    rf_data_in <= entry;
                    if (srx) begin
                        state_reg <= ST_IDLE;
                        rx_busy   <= 1'b0;
                    end else begin
                        state_reg <= ST_WAIT_HIGH;
                    end
                end
                ST_WAIT_HIGH: begin
                    // A held-low line must return high before a new start is accepted
                    if (enable && srx) begin
                        state_reg <= ST_IDLE;
                        rx_busy   <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    rx_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: frames are driven on the serial line and
// the expected FIFO entries are queued, then matched against each rf_push.
module tb_uart_rx_frame;

    logic        clk = 1'b0;
    logic        wb_rst_i;
    logic        enable;
    logic        srx_pad_i;
    logic [7:0]  lcr;
    logic        rx_reset;
    logic        rf_push;
    logic [10:0] rf_data_in;
    logic        rx_busy;

    int tests = 0;
    int fails = 0;
    int push_cnt = 0;
    int base;
    logic prev_push = 1'b0;
    logic [10:0] exp_q[$];

    uart_rx_frame #(.fifo_width(11), .sample_w(4)) dut (
        .clk        (clk),
        .wb_rst_i   (wb_rst_i),
        .enable     (enable),
        .srx_pad_i  (srx_pad_i),
        .lcr        (lcr),
        .rx_reset   (rx_reset),
        .rf_push    (rf_push),
        .rf_data_in (rf_data_in),
        .rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;

    // 16x tick: one clk wide, every third clk
    initial begin
        int div;
        div = 0;
        enable = 1'b0;
        forever begin
            @(negedge clk);
            div = (div == 2) ? 0 : div + 1;
            enable = (div == 2);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every push must match the oldest queued expectation
    initial begin
        logic [10:0] e;
        forever begin
            @(negedge clk);
            if (rf_push === 1'b1) begin
                push_cnt++;
                check("push_one_cycle", {31'd0, prev_push}, 32'd0);
                tests++;
                assert (exp_q.size() != 0)
                else begin
                    fails++;
                    $error("FAIL unexpected_push observed=%0h expected=none", rf_data_in);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    $display("[TB] push entry=%03h expected=%03h", rf_data_in, e);
                    check("entry", {21'd0, rf_data_in}, {21'd0, e});
                end
            end
            prev_push = rf_push;
        end
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!enable) @(posedge clk);
        end
    endtask

    task automatic send_bit(input logic b);
        srx_pad_i = b;
        wait_ticks(16);
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input bit pe,
                              input logic pbit, input logic stop);
        send_bit(1'b0);
        check("busy_mid_frame", {31'd0, rx_busy}, 32'd1);
        for (int i = 0; i < nbits; i++) send_bit(d[i]);
        if (pe) send_bit(pbit);
        send_bit(stop);
        srx_pad_i = 1'b1;
        wait_ticks(32);
        @(negedge clk);
    endtask

    task automatic frame_done(input string tag, input int expect_pushes);
        check({tag, "_push_count"}, push_cnt, expect_pushes);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check({tag, "_idle"}, {31'd0, rx_busy}, 32'd0);
    endtask

    initial begin
        wb_rst_i  = 1'b1;
        srx_pad_i = 1'b1;
        rx_reset  = 1'b0;
        lcr       = 8'h03;
        repeat (4) @(negedge clk);
        check("reset_push", {31'd0, rf_push}, 32'd0);
        check("reset_data", {21'd0, rf_data_in}, 32'd0);
        check("reset_busy", {31'd0, rx_busy}, 32'd0);
        wb_rst_i = 1'b0;
        wait_ticks(32);
        @(negedge clk);

        // 8N1 0x5A
        base = push_cnt;
        exp_q.push_back(11'h2D0);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
        frame_done("8n1", base + 1);

        // 7E1 0x41: correct parity, then flipped parity
        lcr = 8'h1A;
        base = push_cnt;
        exp_q.push_back(11'h208);
        send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1);
        exp_q.push_back(11'h20A);
        send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
        frame_done("7e1", base + 2);

        // Framing error with nonzero data
        lcr = 8'h03;
        base = push_cnt;
        exp_q.push_back(11'h199);
        send_frame(8'h33, 8, 1'b0, 1'b0, 1'b0);
        frame_done("framing", base + 1);

        // Break: line low for two frame times gives a single entry
        base = push_cnt;
        exp_q.push_back(11'h004);
        srx_pad_i = 1'b0;
        wait_ticks(16 * 20);
        @(negedge clk);
        check("break_held_busy", {31'd0, rx_busy}, 32'd1);
        srx_pad_i = 1'b1;
        wait_ticks(32);
        @(negedge clk);
        frame_done("break", base + 1);
        exp_q.push_back(11'h618);
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1);
        frame_done("after_break", base + 2);

        // Start glitch of 4 ticks
        base = push_cnt;
        srx_pad_i = 1'b0;
        wait_ticks(4);
        @(negedge clk);
        check("glitch_busy", {31'd0, rx_busy}, 32'd1);
        srx_pad_i = 1'b1;
        wait_ticks(32);
        @(negedge clk);
        frame_done("glitch", base);

        // rx_reset in the middle of data bit 3, then a clean frame
        base = push_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        srx_pad_i = 1'b1;
        wait_ticks(8);
        @(negedge clk);
        rx_reset = 1'b1;
        @(negedge clk);
        rx_reset = 1'b0;
        check("rx_reset_busy", {31'd0, rx_busy}, 32'd0);
        wait_ticks(32);
        @(negedge clk);
        exp_q.push_back(11'h528);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
        frame_done("rx_reset", base + 1);

        // 5-bit odd parity, then stick parity good and bad
        base = push_cnt;
        lcr = 8'h08;
        exp_q.push_back(11'h0A8);
        send_frame(8'h15, 5, 1'b1, 1'b0, 1'b1);
        lcr = 8'h2B;
        exp_q.push_back(11'h400);
        send_frame(8'h80, 8, 1'b1, 1'b1, 1'b1);
        exp_q.push_back(11'h402);
        send_frame(8'h80, 8, 1'b1, 1'b0, 1'b1);
        frame_done("parity_modes", base + 3);

        // Asynchronous reset mid-frame discards the frame
        lcr = 8'h03;
        base = push_cnt;
        srx_pad_i = 1'b0;
        wait_ticks(24);
        @(negedge clk);
        wb_rst_i = 1'b1;
        #1;
        check("async_reset_busy", {31'd0, rx_busy}, 32'd0);
        check("async_reset_data", {21'd0, rf_data_in}, 32'd0);
        srx_pad_i = 1'b1;
        repeat (3) @(negedge clk);
        wb_rst_i = 1'b0;
        wait_ticks(32);
        @(negedge clk);
        frame_done("async_reset", base);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- UART receive framer. Sits directly upstream of the 16-entry receive FIFO.
- Samples the serial input at 16x baud and assembles 5-8 bit characters.
- Checks parity, stop bit and break on each frame.
- Pushes one 11-bit entry per frame into the FIFO: 8 data bits plus 3 error flags.

Parameters:
- fifo_width, 11, FIFO entry width: bits [10:3] data, bit 2 break, bit 1 parity error, bit 0 framing error.
- sample_w, 4, width of the 16x oversample counter.

Ports:
- clk  input  1  system clock
- wb_rst_i  input  1  asynchronous active-high reset
- enable  input  1  16x-baud tick, one clk wide
- srx_pad_i  input  1  raw serial line, asynchronous to clk
- lcr  input  8  line control: [1:0] chars (00=5, 01=6, 10=7, 11=8 bits), [3] parity enable, [4] even parity, [5] stick parity
- rx_reset  input  1  synchronous abort; framer returns to IDLE
- rf_push  output  1  one-cycle FIFO write strobe
- rf_data_in  output  11  FIFO entry {char[7:0], break, parity_err, framing_err}
- rx_busy  output  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-high, on wb_rst_i.
- Reset values: state=IDLE; synchronizer flops=1; rf_push=0; rf_data_in=0; rx_busy=0; counters=0.
- Input synchronizer: srx_pad_i passes through 2 flops. All decisions below use the synchronized value srx.
- State advance: only on clk edges where enable=1. Exceptions: PUSH advances on the next clk; rx_reset acts on any clk.
- IDLE: on an enable with srx=0, go to START and load the sample counter with 7.
- START: decrement on each enable. At counter=0 (mid start bit):
  - srx=1: false start, return to IDLE, no push.
  - srx=0: go to DATA, load counter with 15, clear the bit index.
- DATA: at counter=0, shift srx into the char LSB-first and reload the counter with 15. After bit (char length - 1), go to PARITY if lcr[3]=1, otherwise STOP.
- Character padding: unused upper bits of char[7:0] are 0.
- PARITY: sample srx at counter=0, then go to STOP.
  - Expected parity: XOR of the received bits, inverted for odd parity (lcr[4]=0).
  - Stick mode (lcr[5]=1): expected bit is ~lcr[4].
  - parity_err = (sampled bit != expected bit).
- STOP: sample at counter=0. framing_err = (srx==0). Go to PUSH.
- Break: break = framing_err & (char==0) & (parity bit sampled 0, or parity disabled). When break=1, entry is {8'h00, 3'b100}; parity and framing flags are suppressed.
- PUSH: assert rf_push=1 for exactly one clk and hold rf_data_in stable until the next push.
  - Next state is IDLE if srx=1, otherwise WAIT_HIGH.
- WAIT_HIGH: prevents one long low period from being seen as repeated breaks. Stay here until srx=1, then go to IDLE.
- Latency: rf_push rises 2 clk after the enable that samples the stop bit.
- rx_reset: forces IDLE, clears counters, and drops rf_push the same cycle. A partial frame is discarded with no push.
- Asynchronous reset mid-frame: immediate return to reset values.
- enable held high continuously: legal; one sample step per clk.
- FIFO full: not checked here. The FIFO flags overrun, and the framer always pushes.
- Width rules: the sample counter wraps modulo 16 and only reloads explicitly. The bit index is 3 bits, compared against lcr[1:0]+4.

Decomposition:
- Shared package (uart_defines): state encodings, and LCR bit positions (bits-per-char, PE, EPS, SP).
- Shared package also holds the error-flag bit positions (BREAK=2, PE=1, FE=0) so FIFO and framer agree.
- Sub-module: uart_sync2, a 2-flop synchronizer with reset value 1. Reusable for cts/dsr inputs.

Test Plan:
- Frame 0x5A, 8N1, lcr=8'h03: exactly one rf_push, rf_data_in=11'h2D0 ({8'h5A,3'b000}), rx_busy back low after the frame.
- Frame 0x41, 7E1, lcr=8'h1A: correct even parity bit -> entry {8'h41,000}. Same frame with the parity bit flipped -> {8'h41,010}.
- Frame 0x33, 8N1, stop bit driven 0 with nonzero data: entry {8'h33,001}.
- Line low for 2 full frame times: exactly one push of {8'h00,100}. No further push until the line returns high and a new start bit arrives.
- Start glitch of 4 enable periods low: no push, framer back in IDLE.
- Assert rx_reset during DATA bit 3, then send a clean 0xA5 frame: one push only, {8'hA5,000}.
